// File: rtl/jk_universal_register.sv
// Multi-mode WIDTH-bit register: hold, load, shift, modulo count, per-bit JK and toggle.
// Optional build macro JK_UNIV_REG_SATURATE_EN makes INC/DEC saturate instead of wrap.
module jk_universal_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] k,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout,
  output logic             tc
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_INC  = 3'b100,
    MODE_DEC  = 3'b101,
    MODE_JK   = 3'b110,
    MODE_TGL  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  mode_e            mode_sel;
  logic             at_top;
  logic             at_zero;
  logic             out_of_range;

  assign mode_sel     = mode_e'(mode);
  assign at_top       = (q_q >= MAX_COUNT);
  assign at_zero      = (q_q == '0);
  assign out_of_range = (q_q > MAX_COUNT);

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode_sel)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_INC: begin
`ifdef JK_UNIV_REG_SATURATE_EN
          q_d = at_top ? MAX_COUNT : q_q + WIDTH'(1);
`else
          q_d = at_top ? '0 : q_q + WIDTH'(1);
`endif
        end
        MODE_DEC: begin
          // Out-of-range values re-enter the count range at the top in both builds.
          if (out_of_range) begin
            q_d = MAX_COUNT;
          end else if (at_zero) begin
`ifdef JK_UNIV_REG_SATURATE_EN
            q_d = '0;
`else
            q_d = MAX_COUNT;
`endif
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
        MODE_JK:  q_d = (d & ~q_q) | (~k & q_q);
        MODE_TGL: q_d = q_q ^ d;
        default:  q_d = q_q;
      endcase
    end
  end

  // sout tracks the mode even while en=0; tc is gated by en.
  always_comb begin
    sout = 1'b0;
    tc   = 1'b0;
    unique case (mode_sel)
      MODE_SHL: sout = q_q[WIDTH-1];
      MODE_SHR: sout = q_q[0];
      MODE_INC: tc   = en & at_top;
      MODE_DEC: tc   = en & at_zero;
      default: begin
        sout = 1'b0;
        tc   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign q_n = ~q_q;

endmodule
